// File: rtl/zmem_dram_port.sv
`timescale 1ns/1ps
// zmem_dram_port: arbitrates each c0..c3 DRAM slot between the Z80 pager
// and video fetch, issues one word command per slot and returns read data.
module zmem_dram_port #(
   parameter int VID_MAXDEFER = 3,
   parameter int DW_CNT       = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        c0,
   input  logic        c1,
   input  logic        c2,
   input  logic        c3,
   input  logic        cpu_req,
   input  logic [20:0] cpu_addr,
   input  logic        cpu_wrbsel,
   input  logic        cpu_rnw,
   input  logic [7:0]  cpu_wrdata,
   output logic        cpu_next,
   output logic        cpu_strobe,
   output logic        cpu_latch,
   output logic [15:0] cpu_rddata,
   input  logic        vid_req,
   input  logic [20:0] vid_addr,
   output logic        vid_next,
   output logic        vid_strobe,
   output logic        dram_req,
   output logic [20:0] dram_addr,
   output logic        dram_rnw,
   output logic [1:0]  dram_bsel,
   output logic [15:0] dram_wrdata,
   input  logic [15:0] dram_rddata
);

   typedef enum logic [1:0] {
      OWN_IDLE,
      OWN_CPU,
      OWN_VID
   } owner_t;

   localparam logic [DW_CNT-1:0] DEFER_MAX = DW_CNT'(VID_MAXDEFER);

   owner_t            owner;
   owner_t            owner_nx;
   logic [DW_CNT-1:0] defer_cnt;
   logic [DW_CNT-1:0] defer_nx;
   logic              vid_force;
   logic              cpu_win;
   logic              vid_win;
   logic              rd_slot;

   always_ff @(posedge clk) begin
      if (rst) begin
         owner     <= OWN_IDLE;
         defer_cnt <= '0;
      end else begin
         owner     <= owner_nx;
         defer_cnt <= defer_nx;
      end
   end

   always_comb begin
      vid_force = vid_req && (defer_cnt == DEFER_MAX);
      cpu_win   = c3 && cpu_req && !vid_force;
      vid_win   = c3 && vid_req && (vid_force || !cpu_req);
      owner_nx  = owner;
      defer_nx  = defer_cnt;
      if (c3) begin
         unique case (1'b1)
            cpu_win: begin
               owner_nx = OWN_CPU;
               if (vid_req && defer_cnt != DEFER_MAX)
                  defer_nx = defer_cnt + 1'b1;
            end
            vid_win: begin
               owner_nx = OWN_VID;
               defer_nx = '0;
            end
            default: owner_nx = OWN_IDLE;
         endcase
      end
   end

   // owner and command register describe the slot in flight until the next c3
   assign rd_slot    = (owner != OWN_IDLE) && dram_rnw;
   assign cpu_next   = c3 && !rst && !vid_force;
   assign vid_next   = vid_win && !rst;
   assign dram_req   = c0 && !rst && (owner != OWN_IDLE);
   assign cpu_strobe = c3 && !rst && rd_slot && (owner == OWN_CPU);
   assign vid_strobe = c3 && !rst && rd_slot && (owner == OWN_VID);

   always_ff @(posedge clk) begin
      if (rst) begin
         dram_addr   <= '0;
         dram_rnw    <= 1'b0;
         dram_bsel   <= 2'b00;
         dram_wrdata <= '0;
         cpu_rddata  <= '0;
         cpu_latch   <= 1'b0;
      end else begin
         if (cpu_win) begin
            dram_addr   <= cpu_addr;
            dram_rnw    <= cpu_rnw;
            dram_wrdata <= {cpu_wrdata, cpu_wrdata};
            if (cpu_rnw)
               dram_bsel <= 2'b11;
            else
               dram_bsel <= cpu_wrbsel ? 2'b10 : 2'b01;
         end else if (vid_win) begin
            dram_addr   <= vid_addr;
            dram_rnw    <= 1'b1;
            dram_bsel   <= 2'b11;
            dram_wrdata <= '0;
         end
         if (c2 && rd_slot)
            cpu_rddata <= dram_rddata;
         // a new CPU grant must never see the previous word as its own
         if (cpu_win || (c2 && rd_slot && owner == OWN_VID))
            cpu_latch <= 1'b0;
         else if (cpu_strobe)
            cpu_latch <= 1'b1;
      end
   end

   a_phase_onehot: assert property (
      @(posedge clk) disable iff (rst) $onehot({c0, c1, c2, c3}));

   a_phase_order: assert property (
      @(posedge clk) disable iff (rst)
      (c0 |=> c1) and (c1 |=> c2) and (c2 |=> c3) and (c3 |=> c0));

endmodule

// File: tb/tb_zmem_dram_port.sv
`timescale 1ns/1ps
// tb_zmem_dram_port: directed stimulus, expectations queued at grant time
// and compared by a negedge monitor when the DUT presents commands/strobes.
module tb_zmem_dram_port;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   int          ph  = 0;
   int          cyc = 0;
   logic        c0, c1, c2, c3;
   logic        cpu_req = 1'b0;
   logic [20:0] cpu_addr = '0;
   logic        cpu_wrbsel = 1'b0;
   logic        cpu_rnw = 1'b1;
   logic [7:0]  cpu_wrdata = '0;
   logic        cpu_next, cpu_strobe, cpu_latch;
   logic [15:0] cpu_rddata;
   logic        vid_req = 1'b0;
   logic [20:0] vid_addr = '0;
   logic        vid_next, vid_strobe;
   logic        dram_req, dram_rnw;
   logic [20:0] dram_addr;
   logic [1:0]  dram_bsel;
   logic [15:0] dram_wrdata, dram_rddata;

   typedef struct {
      logic [20:0] addr;
      logic        rnw;
      logic [1:0]  bsel;
      logic [15:0] wd;
      int          at;
   } cmd_t;
   typedef struct {
      logic        vid;
      logic [15:0] d;
      int          at;
   } rd_t;
   typedef struct {
      string       nm;
      logic [31:0] act;
      logic [31:0] exp;
   } dchk_t;

   cmd_t  cmd_q[$];
   rd_t   rd_q[$];
   logic  nxt_q[$];
   dchk_t dq[$];
   cmd_t  mc;
   rd_t   mr;
   dchk_t md;
   int    errs = 0;
   int    checks = 0;

   assign c0 = (ph == 0);
   assign c1 = (ph == 1);
   assign c2 = (ph == 2);
   assign c3 = (ph == 3);

   function automatic logic [15:0] mem(input logic [20:0] a);
      return a[15:0] ^ 16'h9DAA;
   endfunction

   // DRAM model: data only meaningful on c2, garbage elsewhere
   assign dram_rddata = c2 ? mem(dram_addr) : 16'hDEAD;

   zmem_dram_port dut (
      .clk(clk), .rst(rst),
      .c0(c0), .c1(c1), .c2(c2), .c3(c3),
      .cpu_req(cpu_req), .cpu_addr(cpu_addr),
      .cpu_wrbsel(cpu_wrbsel), .cpu_rnw(cpu_rnw),
      .cpu_wrdata(cpu_wrdata), .cpu_next(cpu_next),
      .cpu_strobe(cpu_strobe), .cpu_latch(cpu_latch),
      .cpu_rddata(cpu_rddata),
      .vid_req(vid_req), .vid_addr(vid_addr),
      .vid_next(vid_next), .vid_strobe(vid_strobe),
      .dram_req(dram_req), .dram_addr(dram_addr),
      .dram_rnw(dram_rnw), .dram_bsel(dram_bsel),
      .dram_wrdata(dram_wrdata), .dram_rddata(dram_rddata)
   );

   always #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      #1;
      ph = (ph + 1) % 4;
      cyc++;
   end

   task automatic do_chk(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   always @(negedge clk) begin
      while (dq.size() > 0) begin
         md = dq.pop_front();
         do_chk(md.nm, md.act, md.exp);
      end
      if (!rst) begin
         if (dram_req) begin
            if (cmd_q.size() == 0)
               do_chk("unexpected dram_req", 32'(dram_req), 32'd0);
            else begin
               mc = cmd_q.pop_front();
               do_chk("dram_addr", 32'(dram_addr), 32'(mc.addr));
               do_chk("dram_rnw", 32'(dram_rnw), 32'(mc.rnw));
               do_chk("dram_bsel", 32'(dram_bsel), 32'(mc.bsel));
               if (!mc.rnw)
                  do_chk("dram_wrdata", 32'(dram_wrdata), 32'(mc.wd));
               do_chk("cmd cycle", 32'(cyc), 32'(mc.at));
            end
         end
         if (cpu_strobe || vid_strobe) begin
            do_chk("dual strobe", 32'(cpu_strobe & vid_strobe), 32'd0);
            if (rd_q.size() == 0)
               do_chk("unexpected strobe", 32'(cpu_strobe | vid_strobe), 32'd0);
            else begin
               mr = rd_q.pop_front();
               do_chk("strobe owner", 32'(vid_strobe), 32'(mr.vid));
               do_chk("rddata", 32'(cpu_rddata), 32'(mr.d));
               do_chk("strobe cycle", 32'(cyc), 32'(mr.at));
            end
         end
         if (c3 && nxt_q.size() > 0)
            do_chk("cpu_next", 32'(cpu_next), 32'(nxt_q.pop_front()));
      end
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      dchk_t d;
      d.nm = nm;
      d.act = act;
      d.exp = exp;
      dq.push_back(d);
   endtask

   task automatic wait_c3();
      int n = 0;
      do begin
         @(posedge clk);
         #2;
         n++;
      end while (!c3 && n < 8);
      if (!c3) begin
         $display("FAIL phase: got %0d want 3", ph);
         $fatal(1, "phase generator stuck");
      end
   endtask

   task automatic push_cmd(input logic [20:0] a, input logic rnw,
                           input logic [1:0] bs, input logic [15:0] wd,
                           input int at);
      cmd_t c;
      c.addr = a;
      c.rnw = rnw;
      c.bsel = bs;
      c.wd = wd;
      c.at = at;
      cmd_q.push_back(c);
   endtask

   task automatic push_rd(input logic v, input logic [15:0] d, input int at);
      rd_t r;
      r.vid = v;
      r.d = d;
      r.at = at;
      rd_q.push_back(r);
   endtask

   // returns #1 after the granting edge, i.e. in the slot's c0 clock
   task automatic cpu_issue(input logic [20:0] a, input logic rnw,
                            input logic bs, input logic [7:0] wd,
                            input bit exp_rd);
      bit got = 0;
      int tries = 0;
      wait_c3();
      cpu_req = 1'b1;
      cpu_addr = a;
      cpu_rnw = rnw;
      cpu_wrbsel = bs;
      cpu_wrdata = wd;
      while (!got && tries < 4) begin
         @(negedge clk);
         if (cpu_next) begin
            got = 1;
            push_cmd(a, rnw, rnw ? 2'b11 : (bs ? 2'b10 : 2'b01),
                     {wd, wd}, cyc + 1);
            if (exp_rd && rnw)
               push_rd(1'b0, mem(a), cyc + 4);
         end
         @(posedge clk);
         #1;
         if (!got) begin
            tries++;
            wait_c3();
         end
      end
      cpu_req = 1'b0;
      chk("cpu grant", 32'(got), 32'd1);
   endtask

   task automatic vid_issue(input logic [20:0] a);
      bit got = 0;
      int tries = 0;
      wait_c3();
      vid_req = 1'b1;
      vid_addr = a;
      while (!got && tries < 8) begin
         @(negedge clk);
         if (vid_next) begin
            got = 1;
            push_cmd(a, 1'b1, 2'b11, 16'h0, cyc + 1);
            push_rd(1'b1, mem(a), cyc + 4);
         end
         @(posedge clk);
         #1;
         if (!got) begin
            tries++;
            wait_c3();
         end
      end
      vid_req = 1'b0;
      chk("vid grant", 32'(got), 32'd1);
   endtask

   initial begin
      int base;
      int n;
      repeat (3) @(posedge clk);
      #2;
      chk("rst cpu_next", 32'(cpu_next), 32'd0);
      chk("rst dram_req", 32'(dram_req), 32'd0);
      chk("rst latch", 32'(cpu_latch), 32'd0);
      chk("rst rddata", 32'(cpu_rddata), 32'd0);
      chk("rst dram_addr", 32'(dram_addr), 32'd0);
      chk("rst defer", 32'(dut.defer_cnt), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // 1: CPU read, hand-computed data 0xBEEF
      cpu_issue(21'h012345, 1'b1, 1'b0, 8'h00, 1'b1);
      repeat (4) @(posedge clk);
      #1;
      chk("t1 rddata", 32'(cpu_rddata), 32'h0000BEEF);
      chk("t1 latch", 32'(cpu_latch), 32'd1);

      // 2: CPU high-byte write, no strobe, rddata untouched
      cpu_issue(21'h000ABC, 1'b0, 1'b1, 8'h5A, 1'b0);
      repeat (4) @(posedge clk);
      #1;
      chk("t2 rddata kept", 32'(cpu_rddata), 32'h0000BEEF);
      chk("t2 latch", 32'(cpu_latch), 32'd0);

      // 4: CPU read then VID read in the following slot
      cpu_issue(21'h1F0F0F, 1'b1, 1'b0, 8'h00, 1'b1);
      vid_issue(21'h0A5A5A);
      chk("t4 latch after cpu c3", 32'(cpu_latch), 32'd1);
      repeat (2) @(posedge clk);
      #1;
      chk("t4 latch before vid c2", 32'(cpu_latch), 32'd1);
      @(posedge clk);
      #1;
      chk("t4 latch after vid c2", 32'(cpu_latch), 32'd0);

      // 5: back-to-back CPU reads, clear beats set
      cpu_issue(21'h000111, 1'b1, 1'b0, 8'h00, 1'b1);
      cpu_issue(21'h000222, 1'b1, 1'b0, 8'h00, 1'b1);
      chk("t5 latch at 2nd grant", 32'(cpu_latch), 32'd0);
      repeat (4) @(posedge clk);
      #1;
      chk("t5 latch at 2nd strobe", 32'(cpu_latch), 32'd1);

      // 3: both requesters held for 8 slots
      wait_c3();
      base = cyc;
      cpu_req = 1'b1;
      cpu_rnw = 1'b1;
      cpu_addr = 21'h033333;
      vid_req = 1'b1;
      vid_addr = 21'h144444;
      for (int i = 0; i < 8; i++) begin
         nxt_q.push_back((i % 4) != 3);
         if ((i % 4) == 3) begin
            push_cmd(21'h144444, 1'b1, 2'b11, 16'h0, base + 4 * i + 1);
            push_rd(1'b1, mem(21'h144444), base + 4 * i + 4);
         end else begin
            push_cmd(21'h033333, 1'b1, 2'b11, 16'h0, base + 4 * i + 1);
            push_rd(1'b0, mem(21'h033333), base + 4 * i + 4);
         end
      end
      repeat (29) @(posedge clk);
      #1;
      cpu_req = 1'b0;
      vid_req = 1'b0;
      repeat (6) @(posedge clk);

      // 6: reset on c1 of a CPU read slot after a deferred video request
      vid_req = 1'b1;
      vid_addr = 21'h055555;
      cpu_issue(21'h066666, 1'b1, 1'b0, 8'h00, 1'b0);
      vid_req = 1'b0;
      chk("t6 defer before rst", 32'(dut.defer_cnt), 32'd1);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #2;
      chk("t6 dram_addr", 32'(dram_addr), 32'd0);
      chk("t6 dram_rnw", 32'(dram_rnw), 32'd0);
      chk("t6 dram_bsel", 32'(dram_bsel), 32'd0);
      chk("t6 rddata", 32'(cpu_rddata), 32'd0);
      chk("t6 latch", 32'(cpu_latch), 32'd0);
      chk("t6 defer", 32'(dut.defer_cnt), 32'd0);
      @(posedge clk);
      #2;
      chk("t6 strobe", 32'({cpu_strobe, vid_strobe, cpu_next}), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (8) @(posedge clk);

      n = 0;
      while ((cmd_q.size() > 0 || rd_q.size() > 0) && n < 50) begin
         @(posedge clk);
         n++;
      end
      chk("leftover cmds", 32'(cmd_q.size()), 32'd0);
      chk("leftover reads", 32'(rd_q.size()), 32'd0);
      repeat (2) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
